// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS words, none/odd/even parity, 1-2 stop bits, valid/ready output.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote around every sample point (one extra cycle of latency).
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 RX_Serial,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Valid,
  input  logic                 RX_Ready,
  output logic                 RX_Parity_Err,
  output logic                 RX_Frame_Err,
  output logic                 RX_Overrun,
  output logic                 RX_Busy
);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 ||
      PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
    $error("uart_rx_cfg: parameter out of legal range");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  state_t                 state, state_nxt;
  logic                   rx_m, rx_s, samp_bit, tick, commit;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err_q, fe_q, fe_now;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX_Serial;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so every decision lands one cycle later.
  localparam int VOTE_DLY = 1;
  logic rx_d1, rx_d2;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end
  assign samp_bit = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
  localparam int VOTE_DLY = 0;
  assign samp_bit = rx_s;
`endif

  localparam logic [CW-1:0] START_LAST = CW'(HALF - 1 + VOTE_DLY);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

  assign tick    = (state == START) ? (cnt == START_LAST) : (cnt == BIT_LAST);
  assign fe_now  = fe_q | ~samp_bit;
  assign RX_Busy = (state != IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = samp_bit ? IDLE : DATA;
      DATA:      if (tick && bit_cnt == 4'(DATA_BITS - 1))
                   state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:    if (tick) state_nxt = STOP;
      STOP:      if (tick && bit_cnt == 4'(STOP_BITS - 1)) begin
                   commit    = 1'b1;
                   state_nxt = samp_bit ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Bit timing and frame accumulation; bit_cnt counts data bits, then is reused for stop bits.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      fe_q      <= 1'b0;
    end else if (state == IDLE) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick && (state == DATA || state == STOP))
        bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
      if (tick && state == DATA)
        shreg <= {samp_bit, shreg[DATA_BITS-1:1]};
      if (tick && state == PARITY)
        par_err_q <= (((^shreg) ^ samp_bit) != (PARITY_MODE == 1));
      if (tick && state == STOP && !samp_bit)
        fe_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      RX_Data       <= '0;
      RX_Valid      <= 1'b0;
      RX_Parity_Err <= 1'b0;
      RX_Frame_Err  <= 1'b0;
      RX_Overrun    <= 1'b0;
    end else begin
      RX_Overrun <= commit && RX_Valid && !RX_Ready;
      if (commit && (!RX_Valid || RX_Ready)) begin
        RX_Data       <= shreg;
        RX_Parity_Err <= par_err_q;
        RX_Frame_Err  <= fe_now;
        RX_Valid      <= 1'b1;
      end else if (RX_Valid && RX_Ready) begin
        RX_Valid <= 1'b0;
      end
    end
  end

endmodule
